// File: rtl/store_unit_rmw_pkg.sv
// Shared definitions for the store unit: store-type codes, FSM state
// encoding and the alignment/legality check applied when a store starts.
package store_pkg;

    localparam logic [1:0] ST_SW  = 2'b00;
    localparam logic [1:0] ST_SH  = 2'b01;
    localparam logic [1:0] ST_SB  = 2'b10;
    localparam logic [1:0] ST_ILL = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_WAIT  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4,
        S_EXC   = 3'd5
    } state_t;

    // True when the request must raise a store exception instead of writing:
    // an illegal type, a halfword on an odd address or a word off a 4-byte boundary.
    function automatic logic store_fault(input logic [1:0] st, input logic [1:0] addr_lo);
        logic fault;
        fault = 1'b0;
        case (st)
            ST_SW:   fault = (addr_lo != 2'b00);
            ST_SH:   fault = addr_lo[0];
            ST_SB:   fault = 1'b0;
            default: fault = 1'b1;
        endcase
        return fault;
    endfunction

endpackage

// File: rtl/store_unit_rmw_if.sv
// Request and memory-port bundle of the store unit. The slave modport is the
// store unit's view; the master modport is the CPU/memory side.
interface store_unit_rmw_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  start;
    logic [1:0]            store_type;
    logic [ADDR_WIDTH-1:0] address;
    logic [31:0]           b_data;
    logic [31:0]           mem_rdata;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic                  mem_wr;
    logic                  busy;
    logic                  done;
    logic                  store_exc;

    modport slave (
        input  start, store_type, address, b_data, mem_rdata,
        output mem_addr, mem_wdata, mem_wr, busy, done, store_exc
    );

    modport master (
        output start, store_type, address, b_data, mem_rdata,
        input  mem_addr, mem_wdata, mem_wr, busy, done, store_exc
    );
endinterface

// File: rtl/store_unit_rmw_merge.sv
// Little-endian lane merger: drops the new halfword/byte into the old word
// at the lane picked by the low address bits; a word store replaces everything.
module store_merge
    import store_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] new_data,
    input  logic [1:0]  store_type,
    input  logic [1:0]  addr_lo,
    output logic [31:0] merged
);
    logic [31:0] lane_mask;
    logic [31:0] lane_data;

    // Build a mask of the bytes being replaced and replicate the new data across all lanes.
    always_comb begin
        // NOTE: defaults first so every path assigns every signal and no latch is inferred.
        lane_mask = 32'h0000_0000;
        lane_data = 32'h0000_0000;
        case (store_type)
            ST_SW: begin
                lane_mask = 32'hFFFF_FFFF;
                lane_data = new_data;
            end
            ST_SH: begin
                lane_mask = 32'h0000_FFFF << {addr_lo[1], 4'b0000};
                lane_data = {2{new_data[15:0]}};
            end
            ST_SB: begin
                lane_mask = 32'h0000_00FF << {addr_lo, 3'b000};
                lane_data = {4{new_data[7:0]}};
            end
            default: ;
        endcase
    end

    assign merged = (old_word & ~lane_mask) | (lane_data & lane_mask);

endmodule

// File: rtl/store_unit_rmw.sv
// Store unit of the multicycle CPU. Word stores go straight to WRITE;
// halfword/byte stores read the old word, merge and write it back, since the
// data memory has no byte enables.
module store_unit_rmw
    import store_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic            clk,
    input  logic            reset,
    store_unit_rmw_if.slave bus
);
    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           data_q;
    logic [1:0]            type_q;
    logic [31:0]           old_q;
    logic [31:0]           merged;
    logic                  accept;

    assign accept = (state_q == S_IDLE) && bus.start;

    store_merge u_merge (
        .old_word   (old_q),
        .new_data   (data_q),
        .store_type (type_q),
        .addr_lo    (addr_q[1:0]),
        .merged     (merged)
    );

    // State register with synchronous reset back to IDLE.
    always_ff @(posedge clk) begin
        // NOTE: sequential state always uses non-blocking assignments.
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Operand latches on acceptance and old-word capture while memory data is valid.
    always_ff @(posedge clk) begin
        // NOTE: these are pure datapath registers; every output is gated by
        // the state, so they are left without reset.
        if (accept) begin
            addr_q <= bus.address;
            data_q <= bus.b_data;
            type_q <= bus.store_type;
        end
        if (state_q == S_WAIT) old_q <= bus.mem_rdata;
    end

    // Next-state decode; requests are only taken in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (store_fault(bus.store_type, bus.address[1:0])) state_d = S_EXC;
                    else if (bus.store_type == ST_SW)                  state_d = S_WRITE;
                    else                                               state_d = S_READ;
                end
            end
            S_READ:  state_d = S_WAIT;
            S_WAIT:  state_d = S_WRITE;
            S_WRITE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            S_EXC:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Moore outputs decoded from the state and the latched operands.
    always_comb begin
        bus.mem_addr  = '0;
        bus.mem_wdata = 32'h0000_0000;
        bus.mem_wr    = 1'b0;
        bus.busy      = 1'b0;
        bus.done      = 1'b0;
        bus.store_exc = 1'b0;
        if (state_q != S_IDLE) begin
            bus.busy     = 1'b1;
            bus.mem_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};
        end
        case (state_q)
            S_WRITE: begin
                bus.mem_wdata = merged;
                // Reset blocks the strobe in the same cycle so an aborted store never commits.
                bus.mem_wr    = ~reset;
            end
            S_DONE:  bus.done      = 1'b1;
            S_EXC:   bus.store_exc = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_store_unit_rmw.sv
// Self-checking bench for store_unit_rmw: a table of directed stores, random
// stores against a byte-level reference model, and hand-written reset and
// ignored-start sequences. Memory is modelled with registered read data.
module tb_store_unit_rmw;
    import store_pkg::*;

    localparam int AW = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    store_unit_rmw_if #(.ADDR_WIDTH(AW)) bus ();

    store_unit_rmw #(.ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Memory environment: 256 words, read data valid the cycle after the address.
    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];
    logic        pre_en;
    logic [7:0]  pre_idx;
    logic [31:0] pre_val;

    always @(posedge clk) begin
        if (bus.mem_wr)  mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
        else if (pre_en) mem[pre_idx] <= pre_val;
        bus.mem_rdata <= mem[bus.mem_addr[9:2]];
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    function automatic logic [127:0] outs(input logic b, input logic d, input logic e,
                                          input logic w, input logic [AW-1:0] a,
                                          input logic [31:0] wd);
        return {60'd0, b, d, e, w, a, wd};
    endfunction

    function automatic logic [127:0] obs();
        return outs(bus.busy, bus.done, bus.store_exc, bus.mem_wr, bus.mem_addr, bus.mem_wdata);
    endfunction

    // Reference: work on a byte array, overwrite the addressed bytes.
    function automatic logic [31:0] ref_merge(input logic [31:0] old, input logic [31:0] data,
                                              input logic [1:0] st, input logic [1:0] lo);
        logic [7:0] b [4];
        for (int k = 0; k < 4; k++) b[k] = old[8*k +: 8];
        if (st == 2'b00) return data;
        if (st == 2'b01) begin
            b[lo[1] * 2]     = data[7:0];
            b[lo[1] * 2 + 1] = data[15:8];
        end else begin
            b[lo] = data[7:0];
        end
        return {b[3], b[2], b[1], b[0]};
    endfunction

    function automatic bit ref_fault(input logic [1:0] st, input logic [1:0] lo);
        return (st == 2'b11) || (st == 2'b00 && lo != 2'b00) || (st == 2'b01 && lo[0]);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    task automatic preload(input logic [7:0] idx, input logic [31:0] val);
        pre_idx = idx;
        pre_val = val;
        pre_en  = 1'b1;
        tick();
        pre_en  = 1'b0;
        ref_mem[idx] = val;
    endtask

    // One store from IDLE, checked cycle by cycle, ending at a negedge in IDLE.
    // With stray=1 start stays high through the busy cycles with garbage operands.
    task automatic run_store(input string tag, input logic [1:0] st, input logic [AW-1:0] addr,
                             input logic [31:0] data, input logic [31:0] exp_wdata,
                             input bit exp_exc, input bit stray);
        logic [7:0]    idx;
        logic [AW-1:0] al;
        idx = addr[9:2];
        al  = {addr[AW-1:2], 2'b00};
        bus.start      = 1'b1;
        bus.store_type = st;
        bus.address    = addr;
        bus.b_data     = data;
        tick();
        bus.start      = stray;
        bus.address    = AW'($urandom_range(0, 1023));
        bus.b_data     = $urandom;
        bus.store_type = 2'($urandom);
        if (exp_exc) begin
            samp(); check({tag, " exc"}, obs(), outs(1, 0, 1, 0, al, 0));
            tick();
        end else begin
            if (st != ST_SW) begin
                samp(); check({tag, " read"}, obs(), outs(1, 0, 0, 0, al, 0));
                tick();
                samp(); check({tag, " wait"}, obs(), outs(1, 0, 0, 0, al, 0));
                tick();
            end
            samp(); check({tag, " write"}, obs(), outs(1, 0, 0, 1, al, exp_wdata));
            tick();
            samp(); check({tag, " done"}, obs(), outs(1, 1, 0, 0, al, 0));
            tick();
            ref_mem[idx] = exp_wdata;
        end
        bus.start = 1'b0;
        samp(); check({tag, " idle"}, obs(), outs(0, 0, 0, 0, 0, 0));
        check({tag, " mem"}, 128'(mem[idx]), 128'(ref_mem[idx]));
    endtask

    // sb at 0x103 aborted by reset in WAIT (stop_in_write=0) or WRITE (=1).
    task automatic reset_mid(input string tag, input bit stop_in_write);
        preload(8'h40, 32'hAABBCCDD);
        bus.start      = 1'b1;
        bus.store_type = ST_SB;
        bus.address    = AW'(32'h103);
        bus.b_data     = 32'h12345678;
        tick();
        bus.start = 1'b0;
        tick();
        if (stop_in_write) tick();
        reset = 1'b1;
        samp(); check({tag, " wr in reset"}, 128'(bus.mem_wr), 128'(0));
        tick();
        reset = 1'b0;
        samp(); check({tag, " outs after"}, obs(), outs(0, 0, 0, 0, 0, 0));
        check({tag, " mem kept"}, 128'(mem[8'h40]), 128'(32'hAABBCCDD));
    endtask

    typedef struct {
        string       name;
        logic [1:0]  st;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
        bit          exc;
    } vec_t;

    vec_t vecs [10];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{"sw 104",  ST_SW,  32'h104, 32'h12345678, 32'h12345678, 1'b0};
        vecs[1] = '{"sb 103",  ST_SB,  32'h103, 32'h12345678, 32'h78BBCCDD, 1'b0};
        vecs[2] = '{"sb 100",  ST_SB,  32'h100, 32'h12345678, 32'hAABBCC78, 1'b0};
        vecs[3] = '{"sb 101",  ST_SB,  32'h101, 32'h12345678, 32'hAABB78DD, 1'b0};
        vecs[4] = '{"sb 102",  ST_SB,  32'h102, 32'h12345678, 32'hAA78CCDD, 1'b0};
        vecs[5] = '{"sh 102",  ST_SH,  32'h102, 32'h12345678, 32'h5678CCDD, 1'b0};
        vecs[6] = '{"sh 100",  ST_SH,  32'h100, 32'h12345678, 32'hAABB5678, 1'b0};
        vecs[7] = '{"sh 101",  ST_SH,  32'h101, 32'h12345678, 32'hAABBCCDD, 1'b1};
        vecs[8] = '{"sw 106",  ST_SW,  32'h106, 32'h12345678, 32'hAABBCCDD, 1'b1};
        vecs[9] = '{"ill 100", ST_ILL, 32'h100, 32'h12345678, 32'hAABBCCDD, 1'b1};

        reset          = 1'b1;
        pre_en         = 1'b0;
        pre_idx        = 8'h00;
        pre_val        = 32'h0;
        bus.start      = 1'b1;
        bus.store_type = ST_SW;
        bus.address    = '0;
        bus.b_data     = 32'h0;
        repeat (3) tick();
        samp(); check("reset outs", obs(), outs(0, 0, 0, 0, 0, 0));
        bus.start = 1'b0;
        tick();
        reset = 1'b0;
        samp(); check("idle after reset", obs(), outs(0, 0, 0, 0, 0, 0));

        for (int i = 0; i < 10; i++) begin
            preload(vecs[i].addr[9:2], 32'hAABBCCDD);
            run_store(vecs[i].name, vecs[i].st, AW'(vecs[i].addr), vecs[i].data,
                      vecs[i].exp, vecs[i].exc, 1'b0);
        end

        // Extra start pulses while busy (READ, WAIT, WRITE, DONE) are ignored.
        preload(8'h40, 32'hAABBCCDD);
        run_store("sb stray", ST_SB, AW'(32'h101), 32'h12345678, 32'hAABB78DD, 1'b0, 1'b1);
        // Start in the IDLE cycle right after DONE is accepted.
        run_store("sw back2back", ST_SW, AW'(32'h108), 32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 1'b0);

        reset_mid("rst wait", 1'b0);
        reset_mid("rst write", 1'b1);

        for (int n = 0; n < 40; n++) begin
            logic [7:0]  idx;
            logic [1:0]  lo, st;
            logic [31:0] data, old;
            bit          flt;
            idx  = 8'($urandom);
            lo   = 2'($urandom);
            st   = 2'($urandom);
            data = $urandom;
            old  = $urandom;
            flt  = ref_fault(st, lo);
            preload(idx, old);
            run_store("rnd", st, AW'({22'd0, idx, lo}), data,
                      flt ? old : ref_merge(old, data, st, lo), flt, 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
